// File: rtl/vga_bus_writer_if.sv
// Bus-side and frame-buffer-side signal bundle for vga_bus_writer.
// The master modport is the processor/testbench side, slave is the writer itself.
interface vga_bus_writer_if #(
  parameter int unsigned X_BITS = 8,
  parameter int unsigned Y_BITS = 7
);
  logic [7:0]               bus_addr;
  logic [7:0]               bus_data_in;
  logic                     bus_we;
  logic [7:0]               bus_data_out;
  logic                     bus_data_oe;
  logic [Y_BITS+X_BITS-1:0] fb_addr;
  logic                     fb_data;
  logic                     fb_we;
  logic [15:0]              config_colours;

  modport master (
    output bus_addr, bus_data_in, bus_we,
    input  bus_data_out, bus_data_oe, fb_addr, fb_data, fb_we, config_colours
  );

  modport slave (
    input  bus_addr, bus_data_in, bus_we,
    output bus_data_out, bus_data_oe, fb_addr, fb_data, fb_we, config_colours
  );
endinterface

// File: rtl/vga_bus_writer.sv
// Bus-mapped VGA frame buffer writer: 8-register window, X/Y auto-increment
// with raster wrap, hardware run-fill engine and readable status.
module vga_bus_writer #(
  parameter logic [7:0]  BASE_ADDR    = 8'hB0,
  parameter int unsigned X_BITS       = 8,
  parameter int unsigned Y_BITS       = 7,
  parameter int unsigned X_MAX        = 160,
  parameter int unsigned Y_MAX        = 120,
  parameter logic [15:0] COLOUR_RESET = 16'h3333
) (
  input logic           clk,
  input logic           reset,
  vga_bus_writer_if.slave bus
);

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(X_MAX - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(Y_MAX - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t state_q, state_d;

  logic [X_BITS-1:0] x_q, x_adv;
  logic [Y_BITS-1:0] y_q, y_adv;
  logic              pix_q;
  logic              auto_inc_q;
  logic [7:0]        fill_len_q;
  logic [7:0]        remaining_q;
  logic [15:0]       colours_q;
  logic              fb_we_q;
  logic [Y_BITS+X_BITS-1:0] fb_addr_q;
  logic              fb_data_q;
  logic [7:0]        data_out_q;
  logic              data_oe_q;

  logic [8:0] off_full;
  logic [2:0] off;
  logic       in_win, wr, rd_status, busy;
  logic       issue, advance, pixel_wr, fill_go;
  logic [7:0] status;

  // Window decode; 9-bit difference keeps addresses below BASE out of range
  assign off_full  = {1'b0, bus.bus_addr} - {1'b0, BASE_ADDR};
  assign in_win    = off_full < 9'd8;
  assign off       = off_full[2:0];
  assign wr        = bus.bus_we && in_win;
  assign rd_status = !bus.bus_we && in_win && (off == 3'd7);
  assign busy      = (state_q == FILL);
  assign status    = {6'b0, auto_inc_q, busy};

  // Raster advance with wrap; out-of-range coordinates fold to 0 here
  always_comb begin
    x_adv = x_q + X_BITS'(1);
    y_adv = y_q;
    if (x_q >= X_LAST) begin
      x_adv = '0;
      y_adv = (y_q >= Y_LAST) ? '0 : y_q + Y_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    advance  = 1'b0;
    pixel_wr = 1'b0;
    fill_go  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr && off == 3'd2) begin
          pixel_wr = 1'b1;
          issue    = 1'b1;
          advance  = auto_inc_q;
        end else if (wr && off == 3'd3 && bus.bus_data_in[1]) begin
          fill_go  = 1'b1;
          issue    = 1'b1;
          advance  = 1'b1;
          state_d  = FILL;
        end
      end
      FILL: begin
        // First pixel was issued on the trigger edge; remaining counts the rest
        if (remaining_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          issue   = 1'b1;
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      pix_q       <= 1'b0;
      auto_inc_q  <= 1'b0;
      fill_len_q  <= 8'd0;
      remaining_q <= 8'd0;
      colours_q   <= COLOUR_RESET;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= 1'b0;
      data_out_q  <= 8'd0;
      data_oe_q   <= 1'b0;
    end else begin
      if (advance) begin
        x_q <= x_adv;
        y_q <= y_adv;
      end else if (wr && !busy) begin
        if (off == 3'd0) y_q <= bus.bus_data_in[Y_BITS-1:0];
        if (off == 3'd1) x_q <= bus.bus_data_in[X_BITS-1:0];
      end

      if (pixel_wr) pix_q <= bus.bus_data_in[0];
      if (wr && !busy && off == 3'd3) auto_inc_q <= bus.bus_data_in[0];
      if (wr && !busy && off == 3'd4) fill_len_q <= bus.bus_data_in;
      if (wr && off == 3'd5) colours_q[7:0]  <= bus.bus_data_in;
      if (wr && off == 3'd6) colours_q[15:8] <= bus.bus_data_in;

      // Length 0 wraps to 255 remaining, giving a 256-pixel run
      if (fill_go)                        remaining_q <= fill_len_q - 8'd1;
      else if (busy && remaining_q != 0)  remaining_q <= remaining_q - 8'd1;

      fb_we_q <= issue;
      if (issue) begin
        fb_addr_q <= {y_q, x_q};
        fb_data_q <= pixel_wr ? bus.bus_data_in[0] : pix_q;
      end

      data_oe_q  <= rd_status;
      data_out_q <= rd_status ? status : 8'd0;
    end
  end

  assign bus.fb_we          = fb_we_q;
  assign bus.fb_addr        = fb_addr_q;
  assign bus.fb_data        = fb_data_q;
  assign bus.bus_data_out   = data_out_q;
  assign bus.bus_data_oe    = data_oe_q;
  assign bus.config_colours = colours_q;

endmodule

// File: tb/tb_vga_bus_writer.sv
// Self-checking bench for vga_bus_writer: directed scenarios plus random
// bus traffic against a transaction-level model of the register window.
module tb_vga_bus_writer;
  localparam int BASE  = 8'hB0;
  localparam int X_MAX = 160;
  localparam int Y_MAX = 120;

  typedef struct {
    int   cyc;
    int   x;
    int   y;
    logic d;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_bus_writer_if #(.X_BITS(8), .Y_BITS(7)) bus ();

  vga_bus_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  wr_t exp_q[$];
  wr_t act_q[$];

  // Reference model state
  int          mx, my, mlen, fill_lo, fill_hi;
  bit          mpix, mauto;
  logic [15:0] mcol;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every frame-buffer write with the edge number that issued it
  always @(posedge clk) begin
    #1;
    if (bus.fb_we === 1'b1)
      act_q.push_back('{cyc, int'(bus.fb_addr[7:0]), int'(bus.fb_addr[14:8]), bus.fb_data});
  end

  function automatic void madv();
    if (mx >= X_MAX - 1) begin
      mx = 0;
      my = (my >= Y_MAX - 1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
  endfunction

  function automatic bit mbusy(int e);
    return (fill_lo < e) && (e <= fill_hi);
  endfunction

  function automatic logic [7:0] mstat(int e);
    return {6'b0, mauto, mbusy(e)};
  endfunction

  function automatic void model_reset(int r);
    wr_t keep[$];
    mx = 0; my = 0; mpix = 0; mauto = 0; mlen = 0;
    mcol = 16'h3333; fill_lo = 0; fill_hi = 0;
    foreach (exp_q[i]) if (exp_q[i].cyc < r) keep.push_back(exp_q[i]);
    exp_q = keep;
  endfunction

  function automatic void model_write(int e, logic [7:0] a, logic [7:0] d);
    int off = int'(a) - BASE;
    bit busy = mbusy(e);
    int len;
    if (off < 0 || off > 7) return;
    case (off)
      0: if (!busy) my = int'(d[6:0]);
      1: if (!busy) mx = int'(d);
      2: if (!busy) begin
        mpix = d[0];
        exp_q.push_back('{e, mx, my, mpix});
        if (mauto) madv();
      end
      3: if (!busy) begin
        mauto = d[0];
        if (d[1]) begin
          len = (mlen == 0) ? 256 : mlen;
          for (int i = 0; i < len; i++) begin
            exp_q.push_back('{e + i, mx, my, mpix});
            madv();
          end
          fill_lo = e;
          fill_hi = e + len;
        end
      end
      4: if (!busy) mlen = int'(d);
      5: mcol[7:0]  = d;
      6: mcol[15:8] = d;
      default: ;
    endcase
  endfunction

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.bus_addr = a; bus.bus_data_in = d; bus.bus_we = 1'b1;
    model_write(cyc + 1, a, d);
    @(posedge clk); #1;
    bus.bus_we = 1'b0; bus.bus_addr = 8'h00;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic oe, output logic [7:0] q, output int e);
    @(negedge clk);
    bus.bus_addr = a; bus.bus_we = 1'b0;
    e = cyc + 1;
    @(posedge clk); #1;
    oe = bus.bus_data_oe; q = bus.bus_data_out;
    bus.bus_addr = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic oe; logic [7:0] q; int e;
    reset = 1'b1;
    bus.bus_addr = 8'h00; bus.bus_data_in = 8'h00; bus.bus_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset(cyc + 1);
    checks++;
    if (bus.fb_we !== 1'b0 || bus.fb_addr !== 15'h0 || bus.fb_data !== 1'b0) begin
      errors++;
      $display("FAIL reset_fb: got we=%b addr=%h data=%b, required 0/0/0", bus.fb_we, bus.fb_addr, bus.fb_data);
    end
    checks++;
    if (bus.bus_data_oe !== 1'b0 || bus.bus_data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus: got oe=%b out=%h, required 0/00", bus.bus_data_oe, bus.bus_data_out);
    end
    checks++;
    if (bus.config_colours !== 16'h3333) begin
      errors++;
      $display("FAIL reset_colours: got %h, required 3333", bus.config_colours);
    end
    @(negedge clk); reset = 1'b0;
    bus_read(8'(BASE + 7), oe, q, e);
    checks++;
    if (oe !== 1'b1 || q !== 8'h00) begin
      errors++;
      $display("FAIL reset_status: got oe=%b data=%h, required 1/00", oe, q);
    end
    idle(1);
    checks++;
    if (bus.bus_data_oe !== 1'b0) begin
      errors++;
      $display("FAIL status_oe_drop: got oe=%b, required 0", bus.bus_data_oe);
    end
    act_q.delete();
  endtask

  task automatic test_single_pixel();
    wr_t ex, ac;
    bus_write(8'(BASE + 0), 8'd5);
    bus_write(8'(BASE + 1), 8'd10);
    bus_write(8'(BASE + 2), 8'd1);
    checks++;
    if (bus.fb_we !== 1'b1 || bus.fb_addr !== 15'h050A || bus.fb_data !== 1'b1) begin
      errors++;
      $display("FAIL pixel_out: got we=%b addr=%h data=%b, required 1/050a/1", bus.fb_we, bus.fb_addr, bus.fb_data);
    end
    idle(1);
    checks++;
    if (bus.fb_we !== 1'b0) begin
      errors++;
      $display("FAIL pixel_pulse: got we=%b one cycle later, required 0", bus.fb_we);
    end
    bus_write(8'(BASE + 2), 8'd0);
    idle(2);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); checks++;
      if (act_q.size() == 0) begin
        errors++; $display("FAIL single_missing: got none, required cyc=%0d x=%0d y=%0d", ex.cyc, ex.x, ex.y);
      end else begin
        ac = act_q.pop_front();
        if (ac.cyc != ex.cyc || ac.x != ex.x || ac.y != ex.y || ac.d !== ex.d) begin
          errors++; $display("FAIL single_write: got cyc=%0d x=%0d y=%0d d=%b, required cyc=%0d x=%0d y=%0d d=%b", ac.cyc, ac.x, ac.y, ac.d, ex.cyc, ex.x, ex.y, ex.d);
        end
      end
    end
    checks++;
    if (act_q.size() != 0) begin errors++; $display("FAIL single_extra: got %0d extra writes, required 0", act_q.size()); end
    act_q.delete();
  endtask

  task automatic test_auto_inc_wrap();
    wr_t ex, ac;
    bus_write(8'(BASE + 3), 8'h01);
    bus_write(8'(BASE + 0), 8'd119);
    bus_write(8'(BASE + 1), 8'd158);
    bus_write(8'(BASE + 2), 8'd1);
    bus_write(8'(BASE + 2), 8'd0);
    bus_write(8'(BASE + 2), 8'd1);
    bus_write(8'(BASE + 2), 8'd0);
    bus_write(8'(BASE + 3), 8'h00);
    idle(2);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); checks++;
      if (act_q.size() == 0) begin
        errors++; $display("FAIL wrap_missing: got none, required cyc=%0d x=%0d y=%0d", ex.cyc, ex.x, ex.y);
      end else begin
        ac = act_q.pop_front();
        if (ac.cyc != ex.cyc || ac.x != ex.x || ac.y != ex.y || ac.d !== ex.d) begin
          errors++; $display("FAIL wrap_write: got cyc=%0d x=%0d y=%0d d=%b, required cyc=%0d x=%0d y=%0d d=%b", ac.cyc, ac.x, ac.y, ac.d, ex.cyc, ex.x, ex.y, ex.d);
        end
      end
    end
    checks++;
    if (act_q.size() != 0) begin errors++; $display("FAIL wrap_extra: got %0d extra writes, required 0", act_q.size()); end
    act_q.delete();
  endtask

  task automatic test_fill();
    wr_t ex, ac;
    logic oe; logic [7:0] q; int e;
    bus_write(8'(BASE + 0), 8'd0);
    bus_write(8'(BASE + 1), 8'd0);
    bus_write(8'(BASE + 2), 8'd1);
    bus_write(8'(BASE + 4), 8'd4);
    bus_write(8'(BASE + 3), 8'h02);
    for (int k = 0; k < 6; k++) begin
      if (k == 1) bus_write(8'(BASE + 1), 8'd77);
      else begin
        bus_read(8'(BASE + 7), oe, q, e);
        checks++;
        if (oe !== 1'b1 || q !== mstat(e)) begin
          errors++; $display("FAIL fill_status: got oe=%b data=%h, required 1/%h", oe, q, mstat(e));
        end
      end
    end
    idle(2);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); checks++;
      if (act_q.size() == 0) begin
        errors++; $display("FAIL fill_missing: got none, required cyc=%0d x=%0d y=%0d", ex.cyc, ex.x, ex.y);
      end else begin
        ac = act_q.pop_front();
        if (ac.cyc != ex.cyc || ac.x != ex.x || ac.y != ex.y || ac.d !== ex.d) begin
          errors++; $display("FAIL fill_write: got cyc=%0d x=%0d y=%0d d=%b, required cyc=%0d x=%0d y=%0d d=%b", ac.cyc, ac.x, ac.y, ac.d, ex.cyc, ex.x, ex.y, ex.d);
        end
      end
    end
    checks++;
    if (act_q.size() != 0) begin errors++; $display("FAIL fill_extra: got %0d extra writes, required 0", act_q.size()); end
    act_q.delete();
  endtask

  task automatic test_fill_256();
    wr_t ex, ac;
    int n;
    bus_write(8'(BASE + 0), 8'd3);
    bus_write(8'(BASE + 1), 8'd100);
    bus_write(8'(BASE + 4), 8'd0);
    bus_write(8'(BASE + 3), 8'h02);
    idle(5);
    bus_write(8'(BASE + 3), 8'h02);
    bus_write(8'(BASE + 5), 8'h5A);
    idle(270);
    n = act_q.size();
    checks++;
    if (n != 256) begin errors++; $display("FAIL fill256_count: got %0d writes, required 256", n); end
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); checks++;
      if (act_q.size() == 0) begin
        errors++; $display("FAIL fill256_missing: got none, required cyc=%0d x=%0d y=%0d", ex.cyc, ex.x, ex.y);
      end else begin
        ac = act_q.pop_front();
        if (ac.cyc != ex.cyc || ac.x != ex.x || ac.y != ex.y || ac.d !== ex.d) begin
          errors++; $display("FAIL fill256_write: got cyc=%0d x=%0d y=%0d d=%b, required cyc=%0d x=%0d y=%0d d=%b", ac.cyc, ac.x, ac.y, ac.d, ex.cyc, ex.x, ex.y, ex.d);
        end
      end
    end
    checks++;
    if (bus.config_colours !== mcol) begin
      errors++; $display("FAIL fill256_colour: got %h, required %h", bus.config_colours, mcol);
    end
    act_q.delete();
  endtask

  task automatic test_random();
    wr_t ex, ac;
    logic oe; logic [7:0] q, a, d; int e, off;
    for (int i = 0; i < 250; i++) begin
      off = $urandom_range(0, 9);
      a = (off > 7) ? 8'($urandom_range(0, 255)) : 8'(BASE + off);
      d = 8'($urandom);
      if (off == 4) d = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 30));
      if (off == 3 && $urandom_range(0, 3) != 0) d[1] = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        bus_read(a, oe, q, e);
        checks++;
        if (int'(a) == BASE + 7) begin
          if (oe !== 1'b1 || q !== mstat(e)) begin
            errors++; $display("FAIL rand_status: got oe=%b data=%h, required 1/%h at cyc %0d", oe, q, mstat(e), e);
          end
        end else if (oe !== 1'b0 || q !== 8'h00) begin
          errors++; $display("FAIL rand_noread: addr %h got oe=%b data=%h, required 0/00", a, oe, q);
        end
      end else begin
        bus_write(a, d);
        checks++;
        if (bus.config_colours !== mcol) begin
          errors++; $display("FAIL rand_colour: got %h, required %h", bus.config_colours, mcol);
        end
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(300);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); checks++;
      if (act_q.size() == 0) begin
        errors++; $display("FAIL rand_missing: got none, required cyc=%0d x=%0d y=%0d", ex.cyc, ex.x, ex.y);
      end else begin
        ac = act_q.pop_front();
        if (ac.cyc != ex.cyc || ac.x != ex.x || ac.y != ex.y || ac.d !== ex.d) begin
          errors++; $display("FAIL rand_write: got cyc=%0d x=%0d y=%0d d=%b, required cyc=%0d x=%0d y=%0d d=%b", ac.cyc, ac.x, ac.y, ac.d, ex.cyc, ex.x, ex.y, ex.d);
        end
      end
    end
    checks++;
    if (act_q.size() != 0) begin errors++; $display("FAIL rand_extra: got %0d extra writes, required 0", act_q.size()); end
    act_q.delete();
  endtask

  task automatic test_reset_mid_fill();
    wr_t ex, ac;
    logic oe; logic [7:0] q; int e;
    bus_write(8'(BASE + 3), 8'h00);
    bus_write(8'(BASE + 0), 8'd5);
    bus_write(8'(BASE + 1), 8'd5);
    bus_write(8'(BASE + 2), 8'd1);
    bus_write(8'(BASE + 6), 8'hC4);
    bus_write(8'(BASE + 4), 8'd10);
    bus_write(8'(BASE + 3), 8'h03);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset(cyc + 1);
    @(posedge clk); #1;
    checks++;
    if (bus.fb_we !== 1'b0) begin
      errors++; $display("FAIL rst_fill_we: got %b, required 0", bus.fb_we);
    end
    checks++;
    if (bus.config_colours !== 16'h3333) begin
      errors++; $display("FAIL rst_fill_colour: got %h, required 3333", bus.config_colours);
    end
    @(negedge clk); reset = 1'b0;
    bus_read(8'(BASE + 7), oe, q, e);
    checks++;
    if (oe !== 1'b1 || q !== 8'h00) begin
      errors++; $display("FAIL rst_fill_status: got oe=%b data=%h, required 1/00", oe, q);
    end
    bus_write(8'(BASE + 2), 8'd1);
    idle(3);
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); checks++;
      if (act_q.size() == 0) begin
        errors++; $display("FAIL rst_fill_missing: got none, required cyc=%0d x=%0d y=%0d", ex.cyc, ex.x, ex.y);
      end else begin
        ac = act_q.pop_front();
        if (ac.cyc != ex.cyc || ac.x != ex.x || ac.y != ex.y || ac.d !== ex.d) begin
          errors++; $display("FAIL rst_fill_write: got cyc=%0d x=%0d y=%0d d=%b, required cyc=%0d x=%0d y=%0d d=%b", ac.cyc, ac.x, ac.y, ac.d, ex.cyc, ex.x, ex.y, ex.d);
        end
      end
    end
    checks++;
    if (act_q.size() != 0) begin errors++; $display("FAIL rst_fill_extra: got %0d extra writes, required 0", act_q.size()); end
    act_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_auto_inc_wrap();
    test_fill();
    test_fill_256();
    test_random();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_bus_writer.md
# vga_bus_writer

Parametrised bus-mapped front end for the VGA frame buffer, successor to the fixed three-register VGA bus interface. It decodes microprocessor bus writes to a configurable register window, drives the frame buffer A-port (address, pixel data, write enable), and holds the 16-bit colour configuration for the signal generator. Beyond single-pixel writes, it adds X/Y auto-increment with raster wrap, a hardware run-fill engine, and a readable status register.

## Interface
Parameters:
- BASE_ADDR, 8'hB0, first address of the 8-register window (BASE..BASE+7)
- X_BITS, 8, X coordinate width
- Y_BITS, 7, Y coordinate width
- X_MAX, 160, pixels per line; X wraps after X_MAX-1
- Y_MAX, 120, lines per frame; Y wraps after Y_MAX-1
- COLOUR_RESET, 16'h3333, reset value of CONFIG_COLOURS

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  system clock
- RESET  in  1  synchronous active-high reset
- BUS_ADDR  in  8  bus address
- BUS_DATA_IN  in  8  bus write data
- BUS_WE  in  1  bus write strobe, one cycle per write
- BUS_DATA_OUT  out  8  read data, registered
- BUS_DATA_OE  out  1  high when BUS_DATA_OUT must drive the bus
- FB_ADDR  out  Y_BITS+X_BITS  frame buffer address {Y, X}
- FB_DATA  out  1  pixel value
- FB_WE  out  1  frame buffer write enable, one-cycle pulses
- CONFIG_COLOURS  out  16  colour pair for the signal generator

## Operation
Register map (offset from BASE_ADDR):
- +0 Y: Y <= DATA[Y_BITS-1:0]. +1 X: X <= DATA[X_BITS-1:0]
- +2 PIXEL: PIX <= DATA[0]; issue one write at current {Y,X}; if AUTO_INC, advance X/Y
- +3 CTRL: bit0 AUTO_INC (sticky); bit1 FILL_GO (self-clearing, reads 0)
- +4 FILL_LEN: run length; 0 encodes 256
- +5 COL_LO -> CONFIG_COLOURS[7:0]; +6 COL_HI -> CONFIG_COLOURS[15:8]
- +7 STATUS (read-only): bit0 BUSY, bit1 AUTO_INC, others 0
- Addresses outside window: no effect, BUS_DATA_OE stays 0

Advance rule: if X >= X_MAX-1 then X <= 0 and (Y >= Y_MAX-1 ? Y <= 0 : Y <= Y+1); else X <= X+1. Out-of-range values written by software wrap on the next advance.

FSM: IDLE, FILL.
- IDLE -> FILL on write to CTRL with bit1=1; load counter from FILL_LEN (0 -> 256)
- FILL: each cycle write PIX at {Y,X}, advance (always, regardless of AUTO_INC), decrement counter; after last pixel -> IDLE
- BUSY = (state == FILL)
- While BUSY: writes to +0..+4 ignored; +5/+6 accepted; STATUS readable

Reads: BUS_WE=0 with BUS_ADDR == BASE+7 -> next cycle BUS_DATA_OE=1, BUS_DATA_OUT=STATUS; otherwise OE=0 and OUT=0.

## Timing
- Reset values: FB_WE=0, FB_ADDR=0, FB_DATA=0, BUS_DATA_OE=0, BUS_DATA_OUT=0, CONFIG_COLOURS=COLOUR_RESET, X=Y=0, PIX=0, AUTO_INC=0, FILL_LEN=0, state IDLE
- PIXEL write at edge N: FB_WE=1 with FB_ADDR/FB_DATA valid in cycle N+1 only; X/Y advance visible from N+1 (FB_ADDR holds pre-advance value)
- Back-to-back PIXEL writes: one FB write per cycle, no stalls
- Fill of length L triggered at edge N: FB_WE high cycles N+1..N+L contiguous; BUSY high N+1..N+L, low from N+L+1
- Status read latency 1 cycle; BUSY is sampled at the read edge
- X/Y/COL register writes take effect the cycle after the edge; no FB_WE
- RESET mid-fill: next cycle IDLE, FB_WE=0, all registers at reset values
- FILL_GO while BUSY: ignored, run not extended

## Test plan
- Reset, read BASE+7 -> BUS_DATA_OE=1 next cycle, DATA_OUT=0x00; CONFIG_COLOURS=16'h3333
- Write Y=5, X=10, PIXEL=1 -> single FB_WE pulse, FB_ADDR={7'd5,8'd10}, FB_DATA=1; X remains 10
- CTRL=0x01, Y=119, X=158, PIXEL 1,0,1 -> writes at (158,119),(159,119),(0,0); final X=1,Y=0
- PIXEL=1, FILL_LEN=4, CTRL=0x02 -> 4 contiguous FB_WE at X 0..3 (Y=0); STATUS reads 0x01 during, 0x00 after; X write during fill ignored
- FILL_LEN=0, trigger -> exactly 256 FB_WE cycles wrapping from X=159 to X=0, Y+1
- RESET asserted after 3 fill pixels -> FB_WE=0 next cycle, STATUS=0x00, X=Y=0
